// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer for a synchronous instruction ROM.
// It keeps the ROM address one instruction ahead so that branches cost no
// bubble cycles. It also holds a 16-entry branch-target table and counts
// retired instructions, saturating at all-ones.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Start,
    output logic [PC_W-1:0]  ImemAddr,
    input  logic [8:0]       ImemData,
    output logic [8:0]       Instruction,
    output logic             InstValid,
    input  logic             BranchEn,
    input  logic [3:0]       TargSel,
    input  logic             Halt,
    input  logic             LutWe,
    input  logic [3:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  Pc,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   lut_q [16];
    logic [PC_W-1:0]   lut_d [16];
    logic [PC_W-1:0]   next_pc;

    // The decoder's branch decision picks the following fetch address. The
    // table is read before this cycle's write lands, so a same-cycle write to
    // the same entry returns the old target.
    always_comb begin
        next_pc = pc_q + PC_W'(1);
        if (BranchEn) begin
            next_pc = lut_q[TargSel];
        end
    end

    // Branch-target table update. A write is accepted in any state.
    always_comb begin
        lut_d = lut_q;
        if (LutWe) begin
            lut_d[LutAddr] = LutData;
        end
    end

    // Sequencer next state and outputs. Outside RUN the ROM is parked on
    // address 0, so instruction 0 is already on the ROM output when RUN starts.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ImemAddr  = '0;
        InstValid = 1'b0;
        Done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                InstValid = 1'b1;
                ImemAddr  = next_pc;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (Halt) begin
                    state_d = HALTED;
                end else begin
                    pc_d = next_pc;
                end
            end
            HALTED: begin
                Done = 1'b1;
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset clears everything at once, including the table.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            lut_q   <= lut_d;
        end
    end

    assign Instruction = ImemData;
    assign Pc          = pc_q;
    assign InstCount   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. A synchronous ROM model supplies the
// instruction data. The counter is narrowed to 4 bits so that saturation is
// reachable in a few cycles.
module tb_fetch_unit;

    localparam int PC_W  = 10;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             ResetN = 1'b1;
    logic             Start = 1'b0;
    logic [PC_W-1:0]  ImemAddr;
    logic [8:0]       ImemData;
    logic [8:0]       Instruction;
    logic             InstValid;
    logic             BranchEn = 1'b0;
    logic [3:0]       TargSel = 4'd0;
    logic             Halt = 1'b0;
    logic             LutWe = 1'b0;
    logic [3:0]       LutAddr = 4'd0;
    logic [PC_W-1:0]  LutData = '0;
    logic [PC_W-1:0]  Pc;
    logic             Done;
    logic [CNT_W-1:0] InstCount;

    int totalChecks = 0;
    int badChecks   = 0;

    fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .ResetN(ResetN), .Start(Start),
        .ImemAddr(ImemAddr), .ImemData(ImemData), .Instruction(Instruction),
        .InstValid(InstValid), .BranchEn(BranchEn), .TargSel(TargSel),
        .Halt(Halt), .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .Pc(Pc), .Done(Done), .InstCount(InstCount)
    );

    always #5 Clk = ~Clk;

    // ROM contents as a function of address.
    function automatic logic [8:0] romVal(input logic [PC_W-1:0] a);
        return a[8:0] ^ {a[9], 8'h5A};
    endfunction

    // Synchronous ROM: data for the address presented this cycle appears next cycle.
    always @(posedge Clk) ImemData <= romVal(ImemAddr);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [3:0] sel, input logic hl);
        Start    = st;
        BranchEn = br;
        TargSel  = sel;
        Halt     = hl;
    endtask

    task automatic checkRun(input string tag, input int pcExp, input int cntExp);
        checkOutput({tag, ".pc"}, 32'(Pc), 32'(pcExp));
        checkOutput({tag, ".cnt"}, 32'(InstCount), 32'(cntExp));
        checkOutput({tag, ".valid"}, 32'(InstValid), 32'd1);
        checkOutput({tag, ".done"}, 32'(Done), 32'd0);
        checkOutput({tag, ".instr"}, 32'(Instruction), 32'(romVal(PC_W'(pcExp))));
    endtask

    task automatic checkQuiet(input string tag, input int pcExp, input int cntExp, input logic doneExp);
        checkOutput({tag, ".pc"}, 32'(Pc), 32'(pcExp));
        checkOutput({tag, ".cnt"}, 32'(InstCount), 32'(cntExp));
        checkOutput({tag, ".valid"}, 32'(InstValid), 32'd0);
        checkOutput({tag, ".done"}, 32'(Done), 32'(doneExp));
        checkOutput({tag, ".addr"}, 32'(ImemAddr), 32'd0);
    endtask

    task automatic writeLut(input logic [3:0] idx, input logic [PC_W-1:0] val);
        LutWe   = 1'b1;
        LutAddr = idx;
        LutData = val;
        cycle();
        LutWe   = 1'b0;
    endtask

    initial begin
        #2 ResetN = 1'b0;
        #1 checkQuiet("reset", 0, 0, 1'b0);
        @(negedge Clk);
        ResetN = 1'b1;

        writeLut(4'd5, 10'h040);
        writeLut(4'd2, 10'h020);
        writeLut(4'd9, 10'h3FE);

        // Branch and halt from the decoder are ignored while idle
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1);
        cycle();
        checkQuiet("idleIgnore", 0, 0, 1'b0);

        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);

        // Straight-line fetch from address 0, then a taken branch at Pc=3
        for (int k = 0; k < 4; k++) begin
            checkRun($sformatf("seq%0d", k), k, k);
            checkOutput($sformatf("seq%0d.addr", k), 32'(ImemAddr), 32'(k + 1));
            if (k < 3) cycle();
        end
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
        #1 checkOutput("branchAddr", 32'(ImemAddr), 32'h040);
        cycle();
        checkRun("branch", 'h040, 4);

        // Same-cycle write and branch through entry 2 uses the old target
        LutWe = 1'b1; LutAddr = 4'd2; LutData = 10'h100;
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0);
        cycle();
        LutWe = 1'b0;
        checkRun("oldTarget", 'h020, 5);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkRun("newTarget", 'h100, 6);

        // Start is ignored in RUN
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        cycle();
        checkRun("startInRun", 'h101, 7);

        // Halt beats branch; a branch while halted is ignored
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
        checkQuiet("halt1", 'h101, 8, 1'b1);
        cycle();
        checkQuiet("haltHold", 'h101, 8, 1'b1);

        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkRun("restart1", 0, 0);
        for (int i = 1; i < 8; i++) cycle();
        checkRun("atPc7", 7, 7);
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkQuiet("halt7", 7, 8, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkRun("restart2", 0, 0);
        cycle();
        checkRun("restart2b", 1, 1);

        // Counter saturates at all-ones
        for (int i = 0; i < 20; i++) cycle();
        checkRun("saturate", 21, 15);

        // Pc wraps from all-ones to zero
        applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkRun("toTop", 'h3FE, 15);
        cycle();
        checkRun("top", 'h3FF, 15);
        checkOutput("wrapAddr", 32'(ImemAddr), 32'd0);
        cycle();
        checkRun("wrap", 0, 15);
        cycle();
        checkRun("afterWrap", 1, 15);

        // Asynchronous reset in the middle of RUN
        #2 ResetN = 1'b0;
        #1 checkQuiet("midReset", 0, 0, 1'b0);
        @(negedge Clk);
        ResetN = 1'b1;
        cycle();
        cycle();
        checkQuiet("waitStart", 0, 0, 1'b0);

        // Reset also cleared the table, so entry 5 now targets address 0
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkRun("lutCleared", 0, 1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
